pll_postdiv_bank: RTL

Multi-channel programmable post-divider with lock sequencing for the PLL clock subsystem. It runs on the PLL output clock and produces NCH registered, 50%-duty divided clocks. Each channel's divide ratio can be changed at run time through its own four-phase req/ack handshake, and the change takes effect only on a glitch-free boundary. Power-down and a lock-delay counter gate all outputs until the clock source is deemed stable. It generalises the single fixed post-divider (pdec/preq/pack) to NCH independently programmable channels.

---
 rtl/pll_postdiv_bank.sv | 139 +++++++++++++
 1 files changed

// File: rtl/pll_postdiv_bank.sv
// pll_postdiv_bank: NCH independently programmable 50%-duty post-dividers
// running on the PLL output clock. Each channel's half-period is updated
// through its own four-phase req/ack handshake. A running channel changes
// only on the boundary into its high phase, so no runt pulse is ever produced.
// Power-down and a lock-delay counter hold every output low until the source
// has been stable for LOCK_CYCLES edges.
module pll_postdiv_bank #(
  parameter int NCH         = 3,
  parameter int DIV_W       = 8,
  parameter int LOCK_CYCLES = 16,
  parameter int DEFAULT_DIV = 4
) (
  input  logic               clkin,
  input  logic               rst,
  input  logic               pd,
  input  logic [NCH-1:0]     req,
  input  logic [NCH*DIV_W-1:0] dec,
  output logic [NCH-1:0]     ack,
  output logic [NCH-1:0]     clkout,
  output logic               lock
);

  localparam int               LW       = $clog2(LOCK_CYCLES + 1);
  localparam logic [LW-1:0]    LOCK_MAX = LW'(LOCK_CYCLES);
  localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(DEFAULT_DIV);

  typedef enum logic [1:0] {IDLE, PEND, ACKD} hs_t;

  logic [LW-1:0]    lcnt;
  hs_t              st       [NCH];
  hs_t              st_nx    [NCH];
  logic [DIV_W-1:0] cur_d    [NCH];
  logic [DIV_W-1:0] cur_d_nx [NCH];
  logic [DIV_W-1:0] cnt      [NCH];
  logic [DIV_W-1:0] cnt_nx   [NCH];
  logic [DIV_W-1:0] dsel     [NCH];
  logic [NCH-1:0]   clk_nx;
  logic [NCH-1:0]   ack_nx;
  logic [NCH-1:0]   run;
  logic [NCH-1:0]   bnd;

  // Lock counter increment that sticks at the lock threshold.
  function automatic logic [LW-1:0] sat_inc(input logic [LW-1:0] v);
    return (v == LOCK_MAX) ? v : v + LW'(1);
  endfunction

  // True on the last count of a half-period.
  function automatic logic at_last(input logic [DIV_W-1:0] c,
                                   input logic [DIV_W-1:0] d);
    return c == (d - DIV_W'(1));
  endfunction

  // Lock delay: cleared by reset or power-down, otherwise counts up and saturates.
  always_ff @(posedge clkin) begin
    if (rst || pd) lcnt <= '0;
    else           lcnt <= sat_inc(lcnt);
  end

  assign lock = (lcnt == LOCK_MAX);

  // Per-channel status: running, and whether this edge is the low->high boundary.
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign dsel[g] = dec[g*DIV_W +: DIV_W];
    assign run[g]  = lock && !pd && (cur_d[g] != '0);
    assign bnd[g]  = run[g] && at_last(cnt[g], cur_d[g]) && !clkout[g];
  end

  // Next-state for divider datapath and handshake FSM of every channel.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      st_nx[i]    = st[i];
      cur_d_nx[i] = cur_d[i];
      cnt_nx[i]   = cnt[i];
      clk_nx[i]   = clkout[i];
      ack_nx[i]   = ack[i];

      if (!run[i]) begin
        cnt_nx[i] = '0;
        clk_nx[i] = 1'b0;
      end else if (at_last(cnt[i], cur_d[i])) begin
        cnt_nx[i] = '0;
        clk_nx[i] = ~clkout[i];
      end else begin
        cnt_nx[i] = cnt[i] + DIV_W'(1);
      end

      unique case (st[i])
        IDLE: begin
          if (req[i] && !ack[i]) st_nx[i] = PEND;
        end
        PEND: begin
          if (!run[i]) begin
            // Stopped channel: load immediately, output stays low.
            cur_d_nx[i] = dsel[i];
            cnt_nx[i]   = '0;
            clk_nx[i]   = 1'b0;
            ack_nx[i]   = 1'b1;
            st_nx[i]    = ACKD;
          end else if (bnd[i]) begin
            // Running channel: new period begins with its high phase;
            // a zero ratio stops the channel after the finished low phase.
            cur_d_nx[i] = dsel[i];
            cnt_nx[i]   = '0;
            clk_nx[i]   = (dsel[i] != '0);
            ack_nx[i]   = 1'b1;
            st_nx[i]    = ACKD;
          end
        end
        ACKD: begin
          if (!req[i]) begin
            ack_nx[i] = 1'b0;
            st_nx[i]  = IDLE;
          end
        end
        default: st_nx[i] = IDLE;
      endcase
    end
  end

  // Channel state registers; reset drops any handshake in flight.
  always_ff @(posedge clkin) begin
    for (int i = 0; i < NCH; i++) begin
      if (rst) begin
        st[i]     <= IDLE;
        cur_d[i]  <= DIV_RST;
        cnt[i]    <= '0;
        clkout[i] <= 1'b0;
        ack[i]    <= 1'b0;
      end else begin
        st[i]     <= st_nx[i];
        cur_d[i]  <= cur_d_nx[i];
        cnt[i]    <= cnt_nx[i];
        clkout[i] <= clk_nx[i];
        ack[i]    <= ack_nx[i];
      end
    end
  end

endmodule
